// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: tag, index, data and register types plus constants.
// Tag value 0 (ZERO_ROB) means "no producer"; a real tag is the entry index + 1.
package reorder_buffer_pkg;

    localparam int ROB_SIZE  = 16;
    localparam int ROB_ID_W  = 5;
    localparam int ROB_IDX_W = $clog2(ROB_SIZE);

    typedef logic [ROB_ID_W-1:0]  ROB_ID_TYPE;
    typedef logic [ROB_IDX_W-1:0] ROB_IDX_TYPE;
    typedef logic [ROB_IDX_W:0]   ROB_CNT_TYPE;
    typedef logic [31:0]          DATA_TYPE;
    typedef logic [31:0]          ADDR_TYPE;
    typedef logic [4:0]           REG_POS_TYPE;

    localparam ROB_ID_TYPE  ZERO_ROB  = '0;
    localparam REG_POS_TYPE ZERO_REG  = '0;
    localparam DATA_TYPE    ZERO_WORD = '0;
    localparam logic        TRUE      = 1'b1;
    localparam logic        FALSE     = 1'b0;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of dispatcher, CDB and register-file signals around the reorder buffer.
// Handshake: alloc_en_from_dsp is the valid, !full_to_dsp is the ready; an entry is taken on an edge where both hold and no rollback pulse is active. cdb_en and the commit/rollback flags are single-cycle strobes without backpressure.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic        alloc_en_from_dsp;
    REG_POS_TYPE rd_from_dsp;
    logic        is_br_from_dsp;
    logic        pred_jump_from_dsp;
    ROB_ID_TYPE  rob_id_to_dsp;
    logic        full_to_dsp;
    ROB_ID_TYPE  q1_from_dsp;
    ROB_ID_TYPE  q2_from_dsp;
    logic        rdy1_to_dsp;
    logic        rdy2_to_dsp;
    DATA_TYPE    v1_to_dsp;
    DATA_TYPE    v2_to_dsp;
    logic        cdb_en;
    ROB_ID_TYPE  cdb_rob_id;
    DATA_TYPE    cdb_value;
    logic        cdb_jump;
    ADDR_TYPE    cdb_target_pc;
    logic        commit_flag_to_rf;
    logic        rollback_flag_to_rf;
    REG_POS_TYPE rd_to_rf;
    ROB_ID_TYPE  Q_to_rf;
    DATA_TYPE    V_to_rf;
    ADDR_TYPE    rollback_pc_to_if;

    modport master (
        output alloc_en_from_dsp, rd_from_dsp, is_br_from_dsp, pred_jump_from_dsp,
        output q1_from_dsp, q2_from_dsp,
        output cdb_en, cdb_rob_id, cdb_value, cdb_jump, cdb_target_pc,
        input  rob_id_to_dsp, full_to_dsp, rdy1_to_dsp, rdy2_to_dsp, v1_to_dsp, v2_to_dsp,
        input  commit_flag_to_rf, rollback_flag_to_rf, rd_to_rf, Q_to_rf, V_to_rf,
        input  rollback_pc_to_if
    );

    modport slave (
        input  alloc_en_from_dsp, rd_from_dsp, is_br_from_dsp, pred_jump_from_dsp,
        input  q1_from_dsp, q2_from_dsp,
        input  cdb_en, cdb_rob_id, cdb_value, cdb_jump, cdb_target_pc,
        output rob_id_to_dsp, full_to_dsp, rdy1_to_dsp, rdy2_to_dsp, v1_to_dsp, v2_to_dsp,
        output commit_flag_to_rf, rollback_flag_to_rf, rd_to_rf, Q_to_rf, V_to_rf,
        output rollback_pc_to_if
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB writeback, in-order commit and mispredict flush.
// Optional ROB_COMMIT_TRACE_EN adds a 64-bit commit counter and commit/rollback trace prints.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave rob
);

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] is_br;
    logic [ROB_SIZE-1:0] pred_jump;
    logic [ROB_SIZE-1:0] real_jump;
    REG_POS_TYPE         rd_q     [ROB_SIZE];
    DATA_TYPE            value_q  [ROB_SIZE];
    ADDR_TYPE            target_q [ROB_SIZE];

    ROB_IDX_TYPE head;
    ROB_IDX_TYPE tail;
    ROB_CNT_TYPE count;

    logic        full;
    logic        alloc_fire;
    logic        wb_fire;
    logic        commit_fire;
    logic        mispredict;
    ROB_IDX_TYPE cdb_idx;

    function automatic ROB_IDX_TYPE wrap_inc(input ROB_IDX_TYPE p);
        return p + ROB_IDX_TYPE'(1);
    endfunction

    // Query result {rdy, value}; a same-cycle CDB write to the tag takes priority over storage.
    function automatic logic [32:0] query(input ROB_ID_TYPE q);
        ROB_IDX_TYPE i;
        i = ROB_IDX_TYPE'(q - ROB_ID_TYPE'(1));
        if (q == ZERO_ROB)
            return {FALSE, ZERO_WORD};
        if (rob.cdb_en && (rob.cdb_rob_id == q))
            return {TRUE, rob.cdb_value};
        return {ready[i], value_q[i]};
    endfunction

    always_comb begin
        full        = (count == ROB_CNT_TYPE'(ROB_SIZE));
        cdb_idx     = ROB_IDX_TYPE'(rob.cdb_rob_id - ROB_ID_TYPE'(1));
        alloc_fire  = rob.alloc_en_from_dsp && !full && !rob.rollback_flag_to_rf;
        wb_fire     = rob.cdb_en && (rob.cdb_rob_id != ZERO_ROB) && busy[cdb_idx]
                      && !rob.rollback_flag_to_rf;
        commit_fire = busy[head] && ready[head] && !rob.rollback_flag_to_rf;
        mispredict  = is_br[head] && (real_jump[head] != pred_jump[head]);
    end

    assign rob.full_to_dsp   = full;
    assign rob.rob_id_to_dsp = ROB_ID_TYPE'(tail) + ROB_ID_TYPE'(1);
    assign {rob.rdy1_to_dsp, rob.v1_to_dsp} = query(rob.q1_from_dsp);
    assign {rob.rdy2_to_dsp, rob.v2_to_dsp} = query(rob.q2_from_dsp);

    // Control state and registered outputs; a rollback pulse flushes the whole buffer at the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            head                    <= '0;
            tail                    <= '0;
            count                   <= '0;
            busy                    <= '0;
            ready                   <= '0;
            rob.commit_flag_to_rf   <= FALSE;
            rob.rollback_flag_to_rf <= FALSE;
            rob.rd_to_rf            <= ZERO_REG;
            rob.Q_to_rf             <= ZERO_ROB;
            rob.V_to_rf             <= ZERO_WORD;
            rob.rollback_pc_to_if   <= ZERO_WORD;
        end else if (rob.rollback_flag_to_rf) begin
            head                    <= '0;
            tail                    <= '0;
            count                   <= '0;
            busy                    <= '0;
            ready                   <= '0;
            rob.commit_flag_to_rf   <= FALSE;
            rob.rollback_flag_to_rf <= FALSE;
        end else begin
            rob.commit_flag_to_rf   <= commit_fire;
            rob.rollback_flag_to_rf <= commit_fire && mispredict;
            if (commit_fire) begin
                rob.rd_to_rf <= rd_q[head];
                rob.Q_to_rf  <= ROB_ID_TYPE'(head) + ROB_ID_TYPE'(1);
                rob.V_to_rf  <= value_q[head];
                if (mispredict)
                    rob.rollback_pc_to_if <= target_q[head];
                busy[head] <= FALSE;
                head       <= wrap_inc(head);
            end
            if (alloc_fire) begin
                busy[tail]  <= TRUE;
                ready[tail] <= FALSE;
                tail        <= wrap_inc(tail);
            end
            if (wb_fire)
                ready[cdb_idx] <= TRUE;
            if (alloc_fire && !commit_fire)
                count <= count + ROB_CNT_TYPE'(1);
            else if (commit_fire && !alloc_fire)
                count <= count - ROB_CNT_TYPE'(1);
        end
    end

    // Entry payload needs no reset: it is only observed through busy/ready.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_q[tail]      <= rob.rd_from_dsp;
            is_br[tail]     <= rob.is_br_from_dsp;
            pred_jump[tail] <= rob.pred_jump_from_dsp;
        end
        if (wb_fire) begin
            value_q[cdb_idx]   <= rob.cdb_value;
            real_jump[cdb_idx] <= rob.cdb_jump;
            target_q[cdb_idx]  <= rob.cdb_target_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rob.alloc_en_from_dsp)
            assert (!full) else $error("reorder_buffer: allocation requested while full");
    end

`ifdef ROB_COMMIT_TRACE_EN
    logic [63:0] commit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt <= '0;
        end else begin
            if (rob.commit_flag_to_rf) begin
                commit_cnt <= commit_cnt + 64'd1;
                $display("rob commit #%0d tag=%0d rd=%0d value=%08h",
                         commit_cnt, rob.Q_to_rf, rob.rd_to_rf, rob.V_to_rf);
            end
            if (rob.rollback_flag_to_rf)
                $display("rob rollback pc=%08h", rob.rollback_pc_to_if);
        end
    end
`endif

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer: allocates a tag per dispatched instruction, collects results from the common data bus (CDB), and retires in program order.
- Producer side of the register-file commit/rollback interface: drives commit, rollback, rd, tag and value into the rename register file.
- Answers dispatcher operand queries so ready-but-uncommitted values bypass the register file.
- Detects branch mispredicts at commit and flushes the machine.

Parameters:
- ROB_SIZE, 16, number of entries (power of two).
- ROB_ID_W, 5, tag width. Tag = entry index + 1; tag 0 (ZERO_ROB) means "no producer".

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_en_from_dsp  in  1  allocate one entry this cycle
- rd_from_dsp  in  5  destination register; 0 means none
- is_br_from_dsp  in  1  entry is a branch or jump needing verification
- pred_jump_from_dsp  in  1  predicted taken
- rob_id_to_dsp  out  ROB_ID_W  tag the next allocation receives (tail+1)
- full_to_dsp  out  1  no free entry
- q1_from_dsp, q2_from_dsp  in  ROB_ID_W  query tags
- rdy1_to_dsp, rdy2_to_dsp  out  1  queried entry has its result
- v1_to_dsp, v2_to_dsp  out  32  queried entry value
- cdb_en  in  1  writeback valid
- cdb_rob_id  in  ROB_ID_W  writeback tag
- cdb_value  in  32  result
- cdb_jump  in  1  actual taken/not-taken
- cdb_target_pc  in  32  correct next PC for the branch
- commit_flag_to_rf  out  1  one-cycle commit pulse
- rollback_flag_to_rf  out  1  one-cycle flush pulse
- rd_to_rf  out  5  committed rd
- Q_to_rf  out  ROB_ID_W  committed tag
- V_to_rf  out  32  committed value
- rollback_pc_to_if  out  32  redirect PC, valid while rollback_flag_to_rf is high

Behaviour:
- **Storage per entry:** busy, ready, rd, value, is_br, pred_jump, real_jump, target_pc.
- **State:** head, tail (index), count (0..ROB_SIZE).
- **Reset:** head = tail = count = 0; all busy and ready bits clear; every registered output 0.
- **Combinational outputs:**
  - full_to_dsp = (count == ROB_SIZE).
  - rob_id_to_dsp = tail + 1.
  - rdy/v query outputs read the addressed entry. A tag of 0 returns rdy = 0, v = 0.
  - A same-cycle CDB write to the queried tag is forwarded: rdy = 1, v = cdb_value.
- **Alloc (edge):** if alloc_en_from_dsp and not full and not rollback_flag_to_rf:
  - entry[tail] gets busy = 1, ready = 0, plus the fields from dsp;
  - tail wraps modulo ROB_SIZE.
  - Alloc while full is ignored and flagged by a simulation assertion.
- **Writeback (edge):** if cdb_en and entry[cdb_rob_id-1] is busy, set ready, value, real_jump and target_pc. Writeback to a non-busy entry is ignored.
- **Commit (edge):** if entry[head] is busy and ready (registered ready; no same-cycle CDB bypass), the next cycle drives:
  - commit_flag_to_rf = 1, rd_to_rf = rd, Q_to_rf = head + 1, V_to_rf = value;
  - then clear busy and advance head.
  - Latency: CDB write at edge N → commit pulse visible in the cycle after edge N+1.
  - Maximum one commit per cycle.
- **Mispredict:** head entry has is_br and real_jump != pred_jump.
  - Commit still occurs (rd written for jal/jalr).
  - rollback_flag_to_rf = 1 in the same cycle; rollback_pc_to_if = target_pc.
  - In the rollback cycle, alloc and CDB inputs are ignored.
  - At the following edge: head = tail = count = 0 and all entries cleared.
- **Simultaneous alloc + commit:** count unchanged; head and tail both advance.
- **Pulses:** commit_flag_to_rf and rollback_flag_to_rf deassert in every cycle without a retire.
- **Reset mid-operation:** full reset state next edge; no commit pulse is emitted.

Optional Feature:
- Macro: ROB_COMMIT_TRACE_EN.
- When defined:
  - 64-bit commit counter, cleared on reset;
  - $display of the counter, tag, rd and value on every commit;
  - $display of rollback_pc on every rollback.
- When undefined: no counter and no display; logic is otherwise identical.

Decomposition:
- Shared defines package holds:
  - ROB_ID_TYPE, ZERO_ROB, ROB_SIZE;
  - DATA_TYPE, ADDR_TYPE, REG_POS_TYPE, ZERO_REG, ZERO_WORD;
  - TRUE/FALSE.
- No sub-module: entry arrays and pointers stay in one module. The head/tail wrap is a local function.

Test Plan:
1. **Simple commit:** reset, alloc rd = 5 (tag 1), CDB tag 1 value 0x2A → one cycle later commit_flag = 1, rd_to_rf = 5, Q_to_rf = 1, V_to_rf = 0x2A; empty afterwards.
2. **In-order retire:** alloc tags 1, 2, 3; CDB 3, then 2, then 1 → commits emitted in order 1, 2, 3 on consecutive cycles after tag 1 is ready.
3. **Fill and wrap:** alloc 16 → full_to_dsp = 1 and a 17th alloc is ignored; commit one, alloc one → new tag 1 reused with wrap; full stays consistent.
4. **Mispredict flush:** branch pred_jump = 0; CDB cdb_jump = 1, target 0x1000; later entries pending → commit + rollback pulses in the same cycle with rollback_pc = 0x1000; count = 0 next cycle and next alloc gets tag 1.
5. **Query bypass:** query tag 2 while CDB writes tag 2 value 7 → rdy2 = 1, v2 = 7 combinationally; query tag 0 → rdy = 0.
6. **Reset mid-stream:** rst with 4 entries, 2 of them ready → no commit pulse; full_to_dsp = 0 and rob_id_to_dsp = 1.
